nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder that feeds one 4-bit carry-lookahead slice per clock and consumes its sum and carry-out. Each cycle it presents one operand nibble plus the registered carry to the slice, then stores the returned sum nibble and carry. It sits between a valid/ready operand source and a valid/ready result sink, trading latency for area on wide operands.

---
 rtl/nsa_pkg.sv | 17 +
 rtl/cla.sv | 28 ++
 rtl/nibble_serial_adder.sv | 106 ++++++++++
 tb/tb_nibble_serial_adder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The adder handles one 4-bit slice per clock; nib_count gives the number of slices.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice.
// All four internal carries come from generate/propagate terms; there is no ripple chain.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead slice per clock, valid/ready on both sides.
// Operands are latched on accept; the result registers hold steady throughout DONE.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  nsa_state_t state, state_next;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  cla u_cla (
    .a    (a_q[int'(idx) * NIBBLE_W +: NIBBLE_W]),
    .b    (b_q[int'(idx) * NIBBLE_W +: NIBBLE_W]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)        state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Operand/result registers change only on accept and during RUN, so outputs hold through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q[int'(idx) * NIBBLE_W +: NIBBLE_W] <= slice_sum;
          carry_q <= slice_cout;
          if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  // MSB operand bits xor sum bit recover the carry into the MSB; xor with carry-out flags overflow.
  assign out_ovf   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_q[WIDTH-1] ^ carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
// Covers reset, latency, carry ripple, overflow, backpressure, mid-run reset and random traffic.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  int checks_total;
  int checks_passed;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits for in_ready, issues one operand pair, then waits for out_valid and returns the latency.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] sum,
                             input logic cout, input logic ovf);
    checkOutput({tag, "_sum"}, {16'd0, out_sum}, {16'd0, sum});
    checkOutput({tag, "_cout"}, {31'd0, out_cout}, {31'd0, cout});
    checkOutput({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
    checkOutput("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int gap;
    int hold;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [WIDTH:0]   full;
    logic             rovf;

    checks_total  = 0;
    checks_passed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    #1;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkResult("reset", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(16'h1234, 16'h4321, 1'b0, lat);
    checkOutput("basic_latency", lat, 32'd4);
    checkOutput("basic_busy_done", {31'd0, busy}, 32'd1);
    checkResult("basic", 16'h5555, 1'b0, 1'b0);
    handshake();

    applyStimulus(16'hFFFF, 16'h0000, 1'b1, lat);
    checkOutput("ripple_latency", lat, 32'd4);
    checkResult("ripple", 16'h0000, 1'b1, 1'b0);
    handshake();

    applyStimulus(16'h7FFF, 16'h0001, 1'b0, lat);
    checkResult("pos_ovf", 16'h8000, 1'b0, 1'b1);
    handshake();

    applyStimulus(16'h8000, 16'h8000, 1'b0, lat);
    checkResult("neg_ovf", 16'h0000, 1'b1, 1'b1);
    handshake();

    // Backpressure: hold DONE for 5 cycles while offering new operands that must be ignored.
    applyStimulus(16'hAAAA, 16'h5555, 1'b0, lat);
    checkResult("bp", 16'hFFFF, 1'b0, 1'b0);
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_sum_stable", {16'd0, out_sum}, 32'h0000FFFF);
    end
    in_valid = 1'b0;
    handshake();
    applyStimulus(16'h1111, 16'h2222, 1'b1, lat);
    checkResult("after_bp", 16'h3334, 1'b0, 1'b0);
    handshake();

    // Asynchronous reset in RUN once idx has reached 2.
    in_a     = 16'hFFFF;
    in_b     = 16'h0001;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("midrun_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkResult("async_rst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(16'h00FF, 16'h0001, 1'b0, lat);
    checkOutput("post_abort_latency", lat, 32'd4);
    checkResult("post_abort", 16'h0100, 1'b0, 1'b0);
    handshake();

    // Random traffic with random idle gaps and random result backpressure.
    for (int k = 0; k < 200; k++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      rovf = (ra[WIDTH-1] == rb[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
      gap  = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      applyStimulus(ra, rb, rc, lat);
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      checkResult("rand", full[WIDTH-1:0], full[WIDTH], rovf);
      handshake();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
